// File: rtl/photon_fifo_rr_arbiter.sv
// Packet-level round-robin merge of N_IN photon FIFO AXI-Stream channels
// into one registered stream tagged with the source channel ID.
//
// Ports:
//   clock, reset          rising-edge clock; synchronous active-high reset
//   s_tvalid/s_tready     per-channel handshake (N_IN bits each)
//   s_tdata/s_tlast       per-channel word (channel i at [i*DW +: DW]) and end of packet
//   m_tvalid/m_tready     registered output handshake
//   m_tdata/m_tlast       registered output word and end of packet
//   m_tdest               source channel of the current output word
//   busy                  high while a packet grant is held
//   stall                 downstream stall flag
//
// Optional build macro PHOTON_ARB_STALL_MON_EN adds a saturating stall
// counter; without it stall is tied low.
module photon_fifo_rr_arbiter #(
  parameter int N_IN        = 4,
  parameter int DW          = 64,
  parameter int IDW         = (N_IN > 1) ? $clog2(N_IN) : 1,
  parameter int STALL_LIMIT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_IN-1:0]   s_tvalid,
  output logic [N_IN-1:0]   s_tready,
  input  logic [N_IN*DW-1:0] s_tdata,
  input  logic [N_IN-1:0]   s_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DW-1:0]     m_tdata,
  output logic              m_tlast,
  output logic [IDW-1:0]    m_tdest,
  output logic              busy,
  output logic              stall
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t state, state_next;

  logic [IDW-1:0] grant, grant_next;
  logic [IDW-1:0] ptr, ptr_next;

  logic [N_IN-1:0] rot;
  logic            found;
  logic [IDW-1:0]  pick;
  logic [IDW:0]    sum;

  logic [DW-1:0]   sel_data;
  logic            sel_valid;
  logic            sel_last;
  logic            out_free;
  logic            accept;

  // Rotate requests so bit k is channel (ptr+k) mod N_IN; the
  // lowest set bit is then the round-robin winner.
  always_comb begin
    rot   = N_IN'({s_tvalid, s_tvalid} >> ptr);
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (IDW+1)'(k);
        if (sum >= (IDW+1)'(N_IN)) begin
          sum = sum - (IDW+1)'(N_IN);
        end
        pick = sum[IDW-1:0];
      end
    end
  end

  // Granted-channel mux.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (grant == IDW'(i)) begin
        sel_data  = s_tdata[i*DW +: DW];
        sel_valid = s_tvalid[i];
        sel_last  = s_tlast[i];
      end
    end
  end

  assign out_free = !m_tvalid || m_tready;
  assign accept   = (state == LOCKED) && sel_valid && out_free;
  assign busy     = (state == LOCKED);

  always_comb begin
    s_tready = '0;
    for (int i = 0; i < N_IN; i++) begin
      s_tready[i] = (state == LOCKED) && out_free &&
                    (grant == IDW'(i));
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    ptr_next   = ptr;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_next = pick;
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && sel_last) begin
          state_next = IDLE;
          ptr_next   = (grant == IDW'(N_IN-1)) ? '0 : grant + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      ptr      <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tdest  <= '0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      ptr   <= ptr_next;
      if (accept) begin
        m_tvalid <= 1'b1;
        m_tdata  <= sel_data;
        m_tlast  <= sel_last;
        m_tdest  <= grant;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

`ifdef PHOTON_ARB_STALL_MON_EN
  logic [31:0] stall_cnt, stall_cnt_next;

  always_comb begin
    stall_cnt_next = '0;
    if (m_tvalid && !m_tready) begin
      stall_cnt_next = (stall_cnt == 32'(STALL_LIMIT)) ?
                       stall_cnt : stall_cnt + 32'd1;
    end
  end

  // Registered from the next count so stall tracks the counter exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
      stall     <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_next;
      stall     <= (stall_cnt_next == 32'(STALL_LIMIT));
    end
  end
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_photon_fifo_rr_arbiter.sv
// Bench for photon_fifo_rr_arbiter: cycle vectors, directed corner
// sequences and randomized traffic against a packet-level scoreboard.
module tb_photon_fifo_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;

  logic              clock;
  logic              reset;
  logic [N-1:0]      s_tvalid;
  logic [N-1:0]      s_tready;
  logic [N*DW-1:0]   s_tdata;
  logic [N-1:0]      s_tlast;
  logic              m_tvalid;
  logic              m_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tlast;
  logic [1:0]        m_tdest;
  logic              busy;
  logic              stall;

  photon_fifo_rr_arbiter #(
    .N_IN(N), .DW(DW), .IDW(2), .STALL_LIMIT(8)
  ) dut (
    .clock(clock), .reset(reset),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast),
    .m_tdest(m_tdest), .busy(busy), .stall(stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  last;
    logic [63:0] word;
    logic        rdy;
    logic        ev;
    logic [63:0] ed;
    logic        el;
    logic [1:0]  edst;
    logic        eb;
    logic [3:0]  er;
  } vec_t;

  int passed = 0;
  int total  = 0;

  word_t src_q [N][$];
  word_t exp_q [N][$];
  int    dlog [$];
  bit    vlog [$];
  logic [N-1:0] vld;
  logic [N-1:0] rdy_smp;
  logic [DW-1:0] smp_data;
  logic smp_valid;
  logic smp_stall;
  bit   in_pkt;
  int   cur_ch;
  int   seq = 0;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic add_words(input int ch, input int n, input bit end_pkt);
    word_t w;
    for (int k = 0; k < n; k++) begin
      w.data = {8'(ch), 24'(seq), 32'($urandom)};
      w.last = end_pkt && (k == n-1);
      seq++;
      src_q[ch].push_back(w);
      exp_q[ch].push_back(w);
    end
  endtask

  task automatic add_pkt(input int ch, input int len);
    add_words(ch, len, 1'b1);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++)
      if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_out();
    word_t w;
    int d;
    d = int'(m_tdest);
    if (exp_q[d].size() == 0) begin
      chk("out_unexpected", {m_tdest, m_tdata}, '1);
    end else begin
      w = exp_q[d].pop_front();
      chk("out_word", {m_tdata, m_tlast}, {w.data, w.last});
    end
    chk("out_framing", 32'(d), in_pkt ? 32'(cur_ch) : 32'(d));
    in_pkt = !m_tlast;
    cur_ch = d;
    dlog.push_back(d);
  endtask

  task automatic cycle(input int pv, input int pr);
    logic [N-1:0] fire;
    word_t w;
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      if (!vld[i] && src_q[i].size() > 0 &&
          $urandom_range(99) < pv) vld[i] = 1'b1;
      s_tvalid[i] = vld[i];
      s_tdata[i*DW +: DW] = vld[i] ? src_q[i][0].data : '0;
      s_tlast[i] = vld[i] ? src_q[i][0].last : 1'b0;
    end
    m_tready = ($urandom_range(99) < pr);
    #1;
    rdy_smp   = s_tready;
    smp_data  = m_tdata;
    smp_valid = m_tvalid;
    smp_stall = stall;
    fire = s_tvalid & s_tready;
    vlog.push_back(m_tvalid);
    if (m_tvalid && m_tready) check_out();
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) begin
      if (fire[i]) begin
        w = src_q[i].pop_front();
        vld[i] = 1'b0;
      end
    end
  endtask

  task automatic drain(input string nm);
    for (int n = 0; n < 600 && !all_empty(); n++) cycle(100, 100);
    chk(nm, all_empty(), 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    vld = '0;
    s_tvalid = '0;
    s_tdata = '0;
    s_tlast = '0;
    m_tready = 1'b0;
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    in_pkt = 1'b0;
    @(posedge clock);
    #1;
    chk("reset_state",
        {m_tvalid, m_tdata, m_tlast, m_tdest, busy, s_tready, stall}, '0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  vec_t vt [11];
  int   exp_gap [6];

  initial begin
    reset = 1'b1;
    s_tvalid = '0;
    s_tdata = '0;
    s_tlast = '0;
    m_tready = 1'b0;
    vld = '0;
    in_pkt = 1'b0;
    cur_ch = 0;
    exp_gap = '{1, 1, 1, 1, 0, 0};

    vt[0]  = '{4'b0100, 4'b0000, 64'hA0, 1, 0, 64'h0,  0, 2'd0, 0, 4'b0000};
    vt[1]  = '{4'b0100, 4'b0000, 64'hA0, 1, 0, 64'h0,  0, 2'd0, 1, 4'b0100};
    vt[2]  = '{4'b0100, 4'b0000, 64'hB0, 1, 1, 64'hA2, 0, 2'd2, 1, 4'b0100};
    vt[3]  = '{4'b0100, 4'b0100, 64'hC0, 1, 1, 64'hB2, 0, 2'd2, 1, 4'b0100};
    vt[4]  = '{4'b0000, 4'b0000, 64'h0,  1, 1, 64'hC2, 1, 2'd2, 0, 4'b0000};
    vt[5]  = '{4'b1001, 4'b1001, 64'h50, 1, 0, 64'h0,  0, 2'd0, 0, 4'b0000};
    vt[6]  = '{4'b1001, 4'b1001, 64'h50, 1, 0, 64'h0,  0, 2'd0, 1, 4'b1000};
    vt[7]  = '{4'b0001, 4'b0001, 64'h50, 1, 1, 64'h53, 1, 2'd3, 0, 4'b0000};
    vt[8]  = '{4'b0001, 4'b0001, 64'h50, 1, 0, 64'h0,  0, 2'd0, 1, 4'b0001};
    vt[9]  = '{4'b0000, 4'b0000, 64'h0,  1, 1, 64'h50, 1, 2'd0, 0, 4'b0000};
    vt[10] = '{4'b0000, 4'b0000, 64'h0,  1, 0, 64'h0,  0, 2'd0, 0, 4'b0000};

    repeat (2) @(posedge clock);
    do_reset();

    // Single channel latency/framing, then ptr=3 makes ch3 beat ch0.
    for (int r = 0; r < 11; r++) begin
      @(negedge clock);
      s_tvalid = vt[r].vld;
      s_tlast  = vt[r].last;
      for (int i = 0; i < N; i++)
        s_tdata[i*DW +: DW] = vt[r].word + 64'(i);
      m_tready = vt[r].rdy;
      #1;
      chk($sformatf("vec[%0d]", r),
          {m_tvalid, m_tvalid ? {m_tdata, m_tlast, m_tdest} : 67'b0,
           busy, s_tready},
          {vt[r].ev, vt[r].ev ? {vt[r].ed, vt[r].el, vt[r].edst} : 67'b0,
           vt[r].eb, vt[r].er});
    end

    // Fairness with all channels continuously offering 2-word packets.
    do_reset();
    for (int i = 0; i < N; i++)
      for (int p = 0; p < 4; p++) add_pkt(i, 2);
    dlog.delete();
    vlog.delete();
    drain("fair_drain");
    chk("fair_count", 32'(dlog.size()), 32'd32);
    for (int k = 0; k < 16 && k < dlog.size(); k++)
      chk($sformatf("fair_dest[%0d]", k), 32'(dlog[k]), 32'((k/2) % 4));
    begin
      int f;
      bit ok;
      f = -1;
      ok = 1'b1;
      for (int j = 0; j < vlog.size(); j++)
        if (f < 0 && vlog[j]) f = j;
      if (f < 0 || f + 12 > vlog.size()) ok = 1'b0;
      else
        for (int j = 0; j < 12; j++)
          if (vlog[f+j] != (j % 3 != 2)) ok = 1'b0;
      chk("fair_bubble", ok, 1'b1);
    end

    // Backpressure mid-packet.
    add_pkt(1, 6);
    dlog.delete();
    for (int n = 0; n < 20 && dlog.size() < 2; n++) cycle(100, 100);
    chk("bp_start", dlog.size() >= 2, 1'b1);
    for (int j = 0; j < 5; j++) begin
      cycle(100, 0);
      chk("bp_hold",
          {smp_valid, smp_data, rdy_smp, smp_stall},
          {1'b1, exp_q[1].size() > 0 ? exp_q[1][0].data : 64'h0,
           4'b0000, 1'b0});
    end
    drain("bp_drain");
    chk("bp_count", 32'(dlog.size()), 32'd6);

    // Granted channel pauses mid-packet while ch0 waits.
    dlog.delete();
    add_words(1, 2, 1'b0);
    for (int n = 0; n < 20 && src_q[1].size() > 0; n++) cycle(100, 100);
    chk("gap_start", src_q[1].size(), 0);
    add_pkt(0, 2);
    for (int j = 0; j < 4; j++) begin
      cycle(100, 100);
      chk("gap_ch0_ready", rdy_smp[0], 1'b0);
    end
    add_words(1, 2, 1'b1);
    drain("gap_drain");
    begin
      bit ok;
      ok = (dlog.size() == 6);
      for (int k = 0; k < 6 && ok; k++)
        if (dlog[k] != exp_gap[k]) ok = 1'b0;
      chk("gap_order", ok, 1'b1);
    end

    // Reset in the middle of a ch2 packet; ptr must restart at 0.
    add_pkt(2, 4);
    dlog.delete();
    for (int n = 0; n < 20 && dlog.size() < 2; n++) cycle(100, 100);
    chk("rst_start", dlog.size() >= 2, 1'b1);
    do_reset();
    add_pkt(3, 1);
    add_pkt(0, 1);
    dlog.delete();
    drain("rst_drain");
    chk("rst_first", dlog.size() > 0 ? 32'(dlog[0]) : 32'hFFFF, 32'd0);

`ifdef PHOTON_ARB_STALL_MON_EN
    add_pkt(3, 3);
    dlog.delete();
    for (int n = 0; n < 20 && dlog.size() < 1; n++) cycle(100, 100);
    for (int j = 0; j < 10; j++) begin
      cycle(100, 0);
      chk($sformatf("stall[%0d]", j), smp_stall, j >= 8);
    end
    cycle(100, 100);
    chk("stall_release", smp_stall, 1'b1);
    cycle(100, 100);
    chk("stall_clear", smp_stall, 1'b0);
    drain("stall_drain");
`endif

    // Randomized traffic with gaps and backpressure.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(3) == 0) begin
        int ch;
        ch = $urandom_range(N-1);
        if (src_q[ch].size() < 8) add_pkt(ch, $urandom_range(1, 4));
      end
      cycle(60, 70);
    end
    drain("rand_drain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
